icache_fetch_mem_responder: RTL and testbench
=============================================

# icache_fetch_mem_responder

Memory-side responder for the ICache fetch path. Accepts line-fetch requests on the `adapter_fetch_mem_req_*` handshake and returns line data with the request tag echoed on the `adapter_fetch_mem_ack_*` handshake. Responses leave strictly in request order after a configurable latency. It sits opposite the ICache memory adapter and stands in for the memory model in ICache-level simulation.

## Interface

**Parameters**
- `DEPTH`, default 8: maximum outstanding requests; power of two, ≥2.
- `LATENCY`, default 4: minimum request-to-response latency in cycles; ≥1.

**Ports**
- `clk` input, 1: single clock; all logic on the rising edge.
- `rst_n` input, 1: reset, synchronous, active-low.
- `adapter_fetch_mem_req_vld` input, 1: request valid.
- `adapter_fetch_mem_req_rdy` output, 1: request ready.
- `adapter_fetch_mem_req_addr` input, ADDR_WIDTH: fetch byte address.
- `adapter_fetch_mem_req_entry_id` input, FETCH_MEM_TAG_WIDTH: opaque tag `{lineA, opcode, mshr idx, txnid}`.
- `adapter_fetch_mem_ack_vld` output, 1: response valid.
- `adapter_fetch_mem_ack_rdy` input, 1: response ready.
- `adapter_fetch_mem_ack_data` output, FETCH_DATA_WIDTH: line data.
- `adapter_fetch_mem_ack_entry_id` output, FETCH_MEM_TAG_WIDTH: echoed tag, bit-exact.

## Operation

- **Storage**
  - Circular queue of DEPTH entries. Each entry holds `{addr, tag, cnt}`.
  - Pointers `wr_ptr`/`rd_ptr` are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter is log2(DEPTH)+1 bits.
- **Push:** on `req_vld && req_rdy`, write the entry at `wr_ptr`, load `cnt = LATENCY-1` plus jitter (see Configuration), then increment `wr_ptr`.
- **Countdown:** every valid entry with `cnt != 0` decrements by 1 each cycle, independently of head status. `cnt` width is clog2(LATENCY+3)+1 bits and saturates at 0.
- **Response:** `ack_vld = (occupancy != 0) && head.cnt == 0`. On `ack_vld && ack_rdy`, increment `rd_ptr`.
- **Data pattern** (deterministic, no backing array):
  - `base` = addr with its low log2(FETCH_DATA_WIDTH/8) bits cleared.
  - 32-bit word k of data = `base + 4*k`, truncated or zero-extended to 32 bits, with word 0 in bits [31:0].
  - Computed combinationally from `head.addr`.
- **Ordering:** strictly FIFO. A younger entry at `cnt == 0` waits behind the head.

## Timing

- **Reset values:** `req_rdy=0` while `rst_n=0`, then 1 from the first cycle after reset deasserts. `ack_vld=0`. `ack_data` and `ack_entry_id` are 0 while empty. Pointers and occupancy are 0; LFSR = 16'hACE1.
- **Latency:** a request accepted at the edge ending cycle T gives `ack_vld` no earlier than cycle T+LATENCY. With no jitter and no backpressure, `ack_vld` rises exactly in cycle T+LATENCY.
- **Throughput:** 1 request and 1 response per cycle, sustained.
- **`req_rdy`:** equals `occupancy != DEPTH`, decoded from registers only. There is no combinational path from `ack_rdy` to `req_rdy`.
- **`ack_vld` ordering:** does not depend on `req_vld`.
- **Full queue:** `req_rdy=0`. A pop in the same cycle frees the slot for the next cycle.
- **Empty queue:** `ack_vld=0`. A push into an empty queue is never visible in the same cycle.
- **Simultaneous push and pop:** occupancy unchanged; both pointers advance.
- **Stable while stalled:** once `ack_vld=1` with `ack_rdy=0`, `ack_vld`, `ack_data` and `ack_entry_id` hold stable until the handshake.
- **Reset mid-operation:** all outstanding entries are discarded with no response. Outputs return to their reset values in the cycle after `rst_n` is sampled low.

## Configuration

- **`FETCH_MEM_RSP_JITTER_EN` defined:**
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances on each accepted request.
  - Each push loads `cnt = LATENCY-1 + lfsr[1:0]`, giving 0–3 extra cycles.
  - Ordering is still FIFO.
- **Not defined:** no LFSR is instantiated and `cnt = LATENCY-1` exactly; latency is fixed.

## Structure

- **toy_pack additions:**
  - `FETCH_MEM_TAG_WIDTH = 1+ICACHE_REQ_OPCODE_WIDTH+MSHR_ENTRY_INDEX_WIDTH+ROB_ENTRY_ID_WIDTH`.
  - `fetch_mem_entry_t` struct `{addr, tag}`.
  - ADDR_WIDTH and FETCH_DATA_WIDTH come from the package.
- **Sub-module:** one, `fetch_mem_lfsr16`, with ports `clk`, `rst_n`, `adv`, `lfsr[15:0]`. It is instantiated only under `FETCH_MEM_RSP_JITTER_EN`.
- **Queue:** inline, because the per-entry countdown rules out a generic FIFO.

## Test plan

Examples use FETCH_DATA_WIDTH=256, LATENCY=4, DEPTH=8, macro off unless stated.

- **Single request:** addr 0x1000, tag 0x15 accepted in cycle 10 -> `ack_vld` rises in cycle 14; data words 0x1000, 0x1004 … 0x101C; tag 0x15.
- **Unaligned address:** addr 0x1013 -> data identical to addr 0x1000; tag echoed bit-exact including the lineA MSB.
- **Fill and drain:** `ack_rdy=0`, 9 back-to-back requests -> 8 accepted, `req_rdy=0` from the cycle after the 8th. Raising `ack_rdy` -> 8 responses in order, one per cycle, with `req_rdy` returning 1 the cycle after the first pop.
- **Push/pop at full:** at full, hold `ack_rdy=1` and `req_vld=1` -> steady 1 push and 1 pop per cycle, occupancy stays between 7 and 8, no tag lost or duplicated.
- **Reset mid-operation:** 3 requests outstanding, `rst_n=0` for 1 cycle -> no responses; next request's ack arrives after exactly LATENCY cycles.
- **Jitter (macro on):** 100 random requests -> every latency within [LATENCY, LATENCY+3], response order equals request order, first jitter value = `16'hACE1[1:0]` = 1.

Source files
------------

// File: rtl/icache_fetch_mem_responder_pkg.sv
// Shared widths, the queued request record and the line-data pattern for the
// ICache fetch memory responder.
package icache_fetch_mem_responder_pkg;

  localparam int ADDR_WIDTH              = 32;
  localparam int FETCH_DATA_WIDTH        = 256;
  localparam int ICACHE_REQ_OPCODE_WIDTH = 2;
  localparam int MSHR_ENTRY_INDEX_WIDTH  = 2;
  localparam int ROB_ENTRY_ID_WIDTH      = 4;
  localparam int FETCH_MEM_TAG_WIDTH     = 1 + ICACHE_REQ_OPCODE_WIDTH + MSHR_ENTRY_INDEX_WIDTH + ROB_ENTRY_ID_WIDTH;
  localparam int FETCH_WORDS             = FETCH_DATA_WIDTH / 32;
  localparam int LINE_OFS_W              = $clog2(FETCH_DATA_WIDTH / 8);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]          addr;
    logic [FETCH_MEM_TAG_WIDTH-1:0] tag;
  } fetch_mem_entry_t;

  // Word k of the line is the byte address of that word within the aligned line.
  function automatic logic [FETCH_DATA_WIDTH-1:0] fetch_line_data(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0]       base;
    logic [FETCH_DATA_WIDTH-1:0] d;
    base = addr & ~ADDR_WIDTH'((1 << LINE_OFS_W) - 1);
    d    = '0;
    for (int k = 0; k < FETCH_WORDS; k++)
      d[k*32 +: 32] = 32'(base + ADDR_WIDTH'(4 * k));
    return d;
  endfunction

endpackage

// File: rtl/icache_fetch_mem_responder_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used for response-latency jitter;
// steps once per accepted request.
module fetch_mem_lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  output logic [15:0] lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign lfsr = r_lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n)   r_lfsr <= 16'hACE1;
    else if (adv) r_lfsr <= {r_lfsr[14:0], w_fb};
  end

endmodule

// File: rtl/icache_fetch_mem_responder.sv
// In-order fetch memory responder: queues requests, counts each down to its
// latency, returns synthesized line data. Define FETCH_MEM_RSP_JITTER_EN for 0-3 cycles of extra latency.
module icache_fetch_mem_responder
  import icache_fetch_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           adapter_fetch_mem_req_vld,
  output logic                           adapter_fetch_mem_req_rdy,
  input  logic [ADDR_WIDTH-1:0]          adapter_fetch_mem_req_addr,
  input  logic [FETCH_MEM_TAG_WIDTH-1:0] adapter_fetch_mem_req_entry_id,
  output logic                           adapter_fetch_mem_ack_vld,
  input  logic                           adapter_fetch_mem_ack_rdy,
  output logic [FETCH_DATA_WIDTH-1:0]    adapter_fetch_mem_ack_data,
  output logic [FETCH_MEM_TAG_WIDTH-1:0] adapter_fetch_mem_ack_entry_id
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = $clog2(LATENCY + 3) + 1;
  localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(LATENCY - 1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);

  fetch_mem_entry_t  r_q   [DEPTH];
  logic [CNT_W-1:0]  r_cnt [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_occ;
  logic              r_up;
  logic              w_push, w_pop, w_empty;
  logic [CNT_W-1:0]  w_load;

`ifdef FETCH_MEM_RSP_JITTER_EN
  logic [15:0] w_lfsr;

  fetch_mem_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (w_push),
    .lfsr  (w_lfsr)
  );

  assign w_load = CNT_BASE + CNT_W'(w_lfsr[1:0]);
`else
  assign w_load = CNT_BASE;
`endif

  // r_up keeps req_rdy low for the first cycle out of reset without any input path.
  assign w_empty                   = (r_occ == '0);
  assign adapter_fetch_mem_req_rdy = r_up && (r_occ != OCC_FULL);
  assign adapter_fetch_mem_ack_vld = !w_empty && (r_cnt[r_rd_ptr] == '0);
  assign w_push = adapter_fetch_mem_req_vld && adapter_fetch_mem_req_rdy;
  assign w_pop  = adapter_fetch_mem_ack_vld && adapter_fetch_mem_ack_rdy;

  assign adapter_fetch_mem_ack_data     = w_empty ? '0 : fetch_line_data(r_q[r_rd_ptr].addr);
  assign adapter_fetch_mem_ack_entry_id = w_empty ? '0 : r_q[r_rd_ptr].tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_up     <= 1'b0;
    end else begin
      r_up <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (PTR_W + 1)'(1);
        2'b01:   r_occ <= r_occ - (PTR_W + 1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Payload needs no reset: it is only observed while the slot is occupied.
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr_ptr] <= '{addr: adapter_fetch_mem_req_addr, tag: adapter_fetch_mem_req_entry_id};
  end

  // Every slot counts down on its own, so a younger entry can reach zero behind the head.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n)                              r_cnt[i] <= '0;
      else if (w_push && r_wr_ptr == PTR_W'(i)) r_cnt[i] <= w_load;
      else if (r_cnt[i] != '0)                  r_cnt[i] <= r_cnt[i] - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_icache_fetch_mem_responder.sv
// Scoreboard bench for icache_fetch_mem_responder: directed scenarios plus random
// traffic, checked every cycle against a queue-based model of due times.
module tb_icache_fetch_mem_responder;
  import icache_fetch_mem_responder_pkg::*;

  localparam int DEPTH      = 8;
  localparam int LATENCY    = 4;
  localparam int DW         = FETCH_DATA_WIDTH;
  localparam int TW         = FETCH_MEM_TAG_WIDTH;
  localparam int LINE_BYTES = FETCH_DATA_WIDTH / 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req_vld = 1'b0;
  logic                  req_rdy;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic [TW-1:0]         req_tag = '0;
  logic                  ack_vld;
  logic                  ack_rdy = 1'b0;
  logic [DW-1:0]         ack_data;
  logic [TW-1:0]         ack_tag;

  always #5 clk = ~clk;

  icache_fetch_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .adapter_fetch_mem_req_vld      (req_vld),
    .adapter_fetch_mem_req_rdy      (req_rdy),
    .adapter_fetch_mem_req_addr     (req_addr),
    .adapter_fetch_mem_req_entry_id (req_tag),
    .adapter_fetch_mem_ack_vld      (ack_vld),
    .adapter_fetch_mem_ack_rdy      (ack_rdy),
    .adapter_fetch_mem_ack_data     (ack_data),
    .adapter_fetch_mem_ack_entry_id (ack_tag)
  );

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [TW-1:0]         tag;
    int                    due;
  } exp_t;

  exp_t  q[$];
  int    cyc = 0;
  int    vectors = 0;
  int    errors = 0;
  bit    prev_rst_n = 1'b0;
  bit    acc_pend = 1'b0;
  exp_t  acc_e;
  logic [15:0] m_lfsr = 16'hACE1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ref_data(input logic [ADDR_WIDTH-1:0] a);
    longint        base;
    logic [DW-1:0] d;
    base = (longint'(a) / LINE_BYTES) * LINE_BYTES;
    d = '0;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = 32'(base + 4 * k);
    return d;
  endfunction

  function automatic int take_jitter();
    int j;
    j = 0;
`ifdef FETCH_MEM_RSP_JITTER_EN
    j = int'(m_lfsr % 16'd4);
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    return j;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One bus cycle: inputs change just after the edge, acceptance is judged mid-cycle
  // and the accepted request joins the scoreboard at the edge that captures it.
  task automatic drv(input bit r, input bit v, input logic [ADDR_WIDTH-1:0] a,
                     input logic [TW-1:0] t, input bit ar);
    @(posedge clk);
    if (acc_pend) begin
      q.push_back(acc_e);
      acc_pend = 1'b0;
    end
    #1;
    rst_n = r; req_vld = v; req_addr = a; req_tag = t; ack_rdy = ar;
    if (!r) m_lfsr = 16'hACE1;
    @(negedge clk);
    if (r && v && req_rdy) begin
      acc_pend   = 1'b1;
      acc_e.addr = a;
      acc_e.tag  = t;
      acc_e.due  = cyc + LATENCY + take_jitter();
    end
  endtask

  always @(negedge clk) begin
    bit exp_vld;
    bit exp_rdy;
    if (cyc >= 1) begin
      exp_vld = prev_rst_n && (q.size() > 0) && (cyc >= q[0].due);
      exp_rdy = prev_rst_n && (q.size() != DEPTH);
      chk("req_rdy", DW'(req_rdy), DW'(exp_rdy));
      chk("ack_vld", DW'(ack_vld), DW'(exp_vld));
      if (exp_vld && ack_vld) begin
        chk("ack_data", ack_data, ref_data(q[0].addr));
        chk("ack_tag", DW'(ack_tag), DW'(q[0].tag));
      end else if (q.size() == 0) begin
        chk("idle_data", ack_data, '0);
        chk("idle_tag", DW'(ack_tag), '0);
      end
      if (exp_vld && ack_rdy) void'(q.pop_front());
      if (!rst_n) q.delete();
    end
    prev_rst_n = rst_n;
  end

  initial begin
    int n;
    repeat (3) drv(0, 0, '0, '0, 1);
    repeat (2) drv(1, 0, '0, '0, 1);

    // single aligned request, then an unaligned one held under backpressure
    drv(1, 1, 32'h0000_1000, TW'(9'h015), 1);
    repeat (8) drv(1, 0, '0, '0, 1);
    drv(1, 1, 32'h0000_1013, TW'(9'h115), 0);
    repeat (7) drv(1, 0, '0, '0, 0);
    repeat (3) drv(1, 0, '0, '0, 1);

    // fill with ack stalled, then drain
    for (int i = 0; i < 9; i++) drv(1, 1, ADDR_WIDTH'(32'h2000 + i * 36), TW'(i + 1), 0);
    repeat (3) drv(1, 0, '0, '0, 0);
    repeat (12) drv(1, 0, '0, '0, 1);

    // sustained push and pop around full
    for (int i = 0; i < 8; i++) drv(1, 1, ADDR_WIDTH'(32'h3000 + i * 32), TW'(i + 32), 0);
    repeat (4) drv(1, 0, '0, '0, 0);
    for (int i = 0; i < 20; i++) drv(1, 1, ADDR_WIDTH'(32'h4000 + i * 40), TW'(i + 64), 1);
    repeat (14) drv(1, 0, '0, '0, 1);

    // reset with work outstanding, then a fresh request
    for (int i = 0; i < 3; i++) drv(1, 1, ADDR_WIDTH'(32'h6000 + i * 32), TW'(i + 100), 0);
    drv(1, 0, '0, '0, 0);
    drv(0, 0, '0, '0, 1);
    drv(1, 0, '0, '0, 1);
    drv(1, 1, 32'h0000_5004, TW'(9'h0AA), 1);
    repeat (8) drv(1, 0, '0, '0, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      drv(1, $urandom_range(0, 3) != 0, ADDR_WIDTH'($urandom), TW'($urandom),
          $urandom_range(0, 3) != 0);

    n = 0;
    while ((q.size() != 0 || acc_pend) && n < 100) begin
      drv(1, 0, '0, '0, 1);
      n++;
    end
    vectors++;
    if (q.size() != 0 || acc_pend) begin
      errors++;
      $display("FAIL drain: %0d responses still outstanding, expected 0", q.size());
    end
    repeat (2) drv(1, 0, '0, '0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
